// File: rtl/cdc_4phase_src_rr.sv
// Source half of a multi-channel 4-phase CDC: round-robin arbiter feeding one req/ack/data bundle.
// Define CDC_4PHASE_SRC_RR_TIMEOUT_EN to add the sticky ack-timeout monitor and timeout_o.
module cdc_4phase_src_rr #(
    parameter int unsigned NumChannels   = 4,
    parameter int unsigned DataWidth     = 8,
    parameter int unsigned SyncStages    = 2,
    parameter bit          Decoupled     = 1'b1,
    parameter int unsigned TimeoutCycles = 255,
    parameter int unsigned ChanW         = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumChannels*DataWidth-1:0] data_i,
    input  logic [NumChannels-1:0]           valid_i,
    output logic [NumChannels-1:0]           ready_o,
    output logic                             async_req_o,
    input  logic                             async_ack_i,
    output logic [DataWidth-1:0]             async_data_o,
    output logic [ChanW-1:0]                 async_chan_o,
    output logic                             busy_o
`ifdef CDC_4PHASE_SRC_RR_TIMEOUT_EN
    ,
    output logic                             timeout_o
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitAckAssert,
        StWaitAckDeassert
    } state_e;

    state_e                 state_q;
    logic                   req_q;
    logic                   busy_q;
    logic [DataWidth-1:0]   data_q;
    logic [ChanW-1:0]       chan_q;
    logic [ChanW-1:0]       ptr_q;
    logic [SyncStages-1:0]  ack_sync_q;
    logic                   ack_s;

    logic [NumChannels-1:0] valid_rot;
    logic                   grant_valid;
    logic [ChanW:0]         grant_sum;
    logic [ChanW-1:0]       grant_idx;
    logic [ChanW-1:0]       ptr_next;
    logic [DataWidth-1:0]   grant_data;

    function automatic logic [NumChannels-1:0] onehot(logic [ChanW-1:0] idx);
        return NumChannels'(1) << idx;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SyncStages-2:0], async_ack_i};
        end
    end
    assign ack_s = ack_sync_q[SyncStages-1];

    // Rotate valids so bit 0 is the pointer channel; the first set bit is the grant.
    always_comb begin
        valid_rot   = NumChannels'({valid_i, valid_i} >> ptr_q);
        grant_valid = 1'b0;
        grant_sum   = '0;
        for (int unsigned k = 0; k < NumChannels; k++) begin
            if (!grant_valid && valid_rot[k]) begin
                grant_valid = 1'b1;
                grant_sum   = {1'b0, ptr_q} + (ChanW+1)'(k);
            end
        end
        if (grant_sum >= (ChanW+1)'(NumChannels)) begin
            grant_sum = grant_sum - (ChanW+1)'(NumChannels);
        end
        grant_idx  = grant_sum[ChanW-1:0];
        ptr_next   = (grant_idx == ChanW'(NumChannels - 1)) ? '0 : grant_idx + 1'b1;
        grant_data = DataWidth'(data_i >> (grant_idx * DataWidth));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        state_q <= StWaitAckAssert;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        data_q  <= grant_data;
                        chan_q  <= grant_idx;
                        ptr_q   <= ptr_next;
                    end
                end
                StWaitAckAssert: begin
                    if (ack_s) begin
                        state_q <= StWaitAckDeassert;
                        req_q   <= 1'b0;
                    end
                end
                StWaitAckDeassert: begin
                    if (!ack_s) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Decoupled consumes on grant; otherwise the item is released only once ack has fallen.
    always_comb begin
        ready_o = '0;
        if (!rst_i) begin
            if (Decoupled) begin
                if (state_q == StIdle && grant_valid) begin
                    ready_o = onehot(grant_idx);
                end
            end else if (state_q == StWaitAckDeassert && !ack_s) begin
                ready_o = onehot(chan_q);
            end
        end
    end

    assign async_req_o  = req_q;
    assign async_data_o = data_q;
    assign async_chan_o = chan_q;
    assign busy_o       = busy_q;

`ifdef CDC_4PHASE_SRC_RR_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] to_cnt_q;
    logic            timeout_q;
    logic            state_change;

    always_comb begin
        state_change = 1'b1;
        case (state_q)
            StIdle:            state_change = grant_valid;
            StWaitAckAssert:   state_change = ack_s;
            StWaitAckDeassert: state_change = !ack_s;
            default:           state_change = 1'b1;
        endcase
    end

    // Counts cycles spent in the current WAIT state; flag is sticky and never aborts the wait.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == StIdle || state_change) begin
            to_cnt_q <= '0;
        end else begin
            if (to_cnt_q != CntW'(TimeoutCycles)) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (to_cnt_q == CntW'(TimeoutCycles - 1)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_cdc_4phase_src_rr.sv
// Bench for cdc_4phase_src_rr: a decoupled and a non-decoupled instance checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_cdc_4phase_src_rr;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SS = 2;
    localparam int TO = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [N-1:0]    valid_a [2];
    logic [N*DW-1:0] data_a  [2];
    logic            ack_a   [2];

    logic [N-1:0]  ready0, ready1;
    logic          req0, req1, busy0, busy1;
    logic [DW-1:0] adata0, adata1;
    logic [1:0]    achan0, achan1;
`ifdef CDC_4PHASE_SRC_RR_TIMEOUT_EN
    logic          to0, to1;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: phase 0 idle, 1 waiting for ack high, 2 waiting for ack low.
    int            m_ph   [2];
    int            m_ptr  [2];
    int            m_chan [2];
    int            m_wcnt [2];
    logic          m_req  [2];
    logic [DW-1:0] m_data [2];
    bit            m_to   [2];
    bit            m_sync [2][SS];

    bit           ack_en  [2];
    bit           rnd_en;
    int           ack_cnt [2];
    int           ack_dly [2];
    logic [N-1:0] cons     [2];
    logic [N-1:0] last_rdy [2];

    always #5 clk = ~clk;

    cdc_4phase_src_rr #(
        .NumChannels  (N),
        .DataWidth    (DW),
        .SyncStages   (SS),
        .Decoupled    (1'b1),
        .TimeoutCycles(TO)
    ) u_dec (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (data_a[0]),
        .valid_i     (valid_a[0]),
        .ready_o     (ready0),
        .async_req_o (req0),
        .async_ack_i (ack_a[0]),
        .async_data_o(adata0),
        .async_chan_o(achan0),
        .busy_o      (busy0)
`ifdef CDC_4PHASE_SRC_RR_TIMEOUT_EN
        ,
        .timeout_o   (to0)
`endif
    );

    cdc_4phase_src_rr #(
        .NumChannels  (N),
        .DataWidth    (DW),
        .SyncStages   (SS),
        .Decoupled    (1'b0),
        .TimeoutCycles(TO)
    ) u_nd (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (data_a[1]),
        .valid_i     (valid_a[1]),
        .ready_o     (ready1),
        .async_req_o (req1),
        .async_ack_i (ack_a[1]),
        .async_data_o(adata1),
        .async_chan_o(achan1),
        .busy_o      (busy1)
`ifdef CDC_4PHASE_SRC_RR_TIMEOUT_EN
        ,
        .timeout_o   (to1)
`endif
    );

    function automatic logic [N-1:0] f_ready(int i); return (i == 0) ? ready0 : ready1; endfunction
    function automatic logic f_req(int i);           return (i == 0) ? req0 : req1;     endfunction
    function automatic logic f_busy(int i);          return (i == 0) ? busy0 : busy1;   endfunction
    function automatic logic [DW-1:0] f_data(int i); return (i == 0) ? adata0 : adata1; endfunction
    function automatic logic [1:0] f_chan(int i);    return (i == 0) ? achan0 : achan1; endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int grant_of(int i);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr[i] + k) % N;
            if (valid_a[i][c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(int i);
        int g;
        if (rst) return '0;
        if (i == 0) begin
            g = grant_of(i);
            if (m_ph[i] == 0 && g >= 0) return N'(1) << g;
        end else if (m_ph[i] == 2 && !m_sync[i][SS-1]) begin
            return N'(1) << m_chan[i];
        end
        return '0;
    endfunction

    task automatic model_reset(int i);
        m_ph[i] = 0; m_ptr[i] = 0; m_chan[i] = 0; m_wcnt[i] = 0;
        m_req[i] = 1'b0; m_data[i] = '0; m_to[i] = 1'b0;
        for (int s = 0; s < SS; s++) m_sync[i][s] = 1'b0;
    endtask

    task automatic model_step(int i);
        int  old, g;
        bit  acks;
        if (rst) begin
            model_reset(i);
            return;
        end
        acks = m_sync[i][SS-1];
        old  = m_ph[i];
        if (m_ph[i] == 0) begin
            g = grant_of(i);
            if (g >= 0) begin
                m_req[i]  = 1'b1;
                m_data[i] = data_a[i][g*DW +: DW];
                m_chan[i] = g;
                m_ptr[i]  = (g + 1) % N;
                m_ph[i]   = 1;
            end
        end else if (m_ph[i] == 1) begin
            if (acks) begin m_req[i] = 1'b0; m_ph[i] = 2; end
        end else if (!acks) begin
            m_ph[i] = 0;
        end
        if (m_ph[i] != old || m_ph[i] == 0) m_wcnt[i] = 0;
        else begin
            m_wcnt[i]++;
            if (m_wcnt[i] == TO) m_to[i] = 1'b1;
        end
        for (int s = SS - 1; s > 0; s--) m_sync[i][s] = m_sync[i][s-1];
        m_sync[i][0] = ack_a[i];
    endtask

    task automatic compare(int i);
        check($sformatf("ready%0d", i), f_ready(i), exp_ready(i));
        check($sformatf("req%0d", i), f_req(i), m_req[i]);
        check($sformatf("data%0d", i), f_data(i), m_data[i]);
        check($sformatf("chan%0d", i), f_chan(i), m_chan[i]);
        check($sformatf("busy%0d", i), f_busy(i), m_ph[i] != 0);
`ifdef CDC_4PHASE_SRC_RR_TIMEOUT_EN
        check($sformatf("timeout%0d", i), (i == 0) ? to0 : to1, m_to[i]);
`endif
    endtask

    task automatic drive_acks();
        for (int i = 0; i < 2; i++) begin
            if (ack_en[i]) begin
                if (ack_a[i] != f_req(i)) begin
                    ack_cnt[i]++;
                    if (ack_cnt[i] >= ack_dly[i]) begin
                        ack_a[i]   = f_req(i);
                        ack_cnt[i] = 0;
                        if (rnd_en) ack_dly[i] = int'($urandom_range(1, 4));
                    end
                end else begin
                    ack_cnt[i] = 0;
                end
            end
        end
    endtask

    task automatic drive_rand();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < N; c++) begin
                if (cons[i][c] || !valid_a[i][c]) begin
                    valid_a[i][c]         = ($urandom_range(0, 2) != 0);
                    data_a[i][c*DW +: DW] = DW'($urandom);
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            compare(i);
            last_rdy[i] = f_ready(i);
            cons[i]     = exp_ready(i) & valid_a[i];
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        drive_acks();
        if (rnd_en) drive_rand();
    endtask

    task automatic wait_idle(int i);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (f_busy(i) && n < 60);
        if (f_busy(i)) check($sformatf("idle_wait%0d", i), 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            ack_a[i]   = 1'b0;
            ack_cnt[i] = 0;
        end
        #1;
        check("rst_req", req0, 0);
        check("rst_chan", achan0, 0);
        check("rst_data", adata0, 0);
        check("rst_busy", busy0, 0);
        check("rst_ready", ready0, 0);
        check("rst_req_nd", req1, 0);
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, first_at, pulses, got;
        int grants[$];
        for (int i = 0; i < 2; i++) begin
            valid_a[i] = '0; data_a[i] = '0; ack_a[i] = 1'b0;
            ack_en[i] = 1'b1; ack_dly[i] = 3; ack_cnt[i] = 0;
            cons[i] = '0; last_rdy[i] = '0;
        end
        rnd_en = 1'b0;
        #2;
        do_reset();

        // Single transfer on channel 2 with a 3-cycle ack loopback.
        valid_a[0] = 4'b0100;
        data_a[0][2*DW +: DW] = 8'hA5;
        #1;
        check("single_ready", ready0, 4'b0100);
        cycle();
        valid_a[0] = '0;
        check("single_req", req0, 1);
        check("single_data", adata0, 8'hA5);
        check("single_chan", achan0, 2);
        check("single_busy", busy0, 1);
        check("model_chan", m_chan[0], 2);
        n = 0;
        while (req0 && n < 20) begin cycle(); n++; end
        check("req_drop_cycles", n, 5);
        while (busy0 && n < 40) begin cycle(); n++; end
        check("busy_low_cycles", n, 10);

        // Pointer sits at 3: only channel 0 valid wraps to 0, pointer then 1.
        valid_a[0] = 4'b0001;
        data_a[0][0 +: DW] = 8'h11;
        #1;
        check("wrap_ready", ready0, 4'b0001);
        cycle();
        valid_a[0] = '0;
        check("wrap_chan", achan0, 0);
        wait_idle(0);
        valid_a[0] = 4'b0011;
        data_a[0][DW +: DW] = 8'h22;
        #1;
        check("wrap_ptr", ready0, 4'b0010);
        cycle();
        valid_a[0] = '0;
        check("wrap_data", adata0, 8'h22);
        wait_idle(0);

        // Reset in WAIT_ACK_ASSERT after granting channel 1 (pointer would be 2).
        valid_a[0] = 4'b0010;
        cycle();
        valid_a[0] = '0;
        check("pre_rst_req", req0, 1);
        do_reset();
        valid_a[0] = 4'b0101;
        #1;
        check("post_rst_grant", ready0, 4'b0001);
        cycle();
        valid_a[0] = '0;
        wait_idle(0);

        // Round-robin fairness with all four channels always valid.
        do_reset();
        valid_a[0] = 4'b1111;
        data_a[0]  = 32'h44332211;
        n = 0;
        while (grants.size() < 5 && n < 200) begin
            cycle();
            n++;
            for (int c = 0; c < N; c++) if (last_rdy[0][c]) grants.push_back(c);
        end
        valid_a[0] = '0;
        for (int k = 0; k < 5; k++) begin
            got = (k < grants.size()) ? grants[k] : -1;
            check($sformatf("rr_order%0d", k), got, k % N);
        end
        wait_idle(0);

        // Non-decoupled: ready pulses once, when synchronised ack falls.
        valid_a[1] = 4'b0010;
        data_a[1][DW +: DW] = 8'h3C;
        first_at = 0;
        pulses   = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (last_rdy[1] != '0) begin
                check("nd_ready_bit", last_rdy[1], 4'b0010);
                pulses++;
                if (first_at == 0) first_at = k;
                valid_a[1] = '0;
            end
        end
        check("nd_pulse_cycle", first_at, 11);
        check("nd_pulse_count", pulses, 1);
        check("nd_data", adata1, 8'h3C);
        check("nd_chan", achan1, 1);

`ifdef CDC_4PHASE_SRC_RR_TIMEOUT_EN
        // Destination never acks: flag rises exactly TO cycles into WAIT_ACK_ASSERT.
        do_reset();
        ack_en[0]  = 1'b0;
        valid_a[0] = 4'b0001;
        cycle();
        valid_a[0] = '0;
        n = 0;
        while (!to0 && n < 40) begin cycle(); n++; end
        check("timeout_cycles", n, TO);
        repeat (5) cycle();
        check("timeout_sticky", to0, 1);
        ack_en[0] = 1'b1;
        wait_idle(0);
        check("timeout_after_ack", to0, 1);
        check("timeout_done_busy", busy0, 0);
`endif

        // Randomised traffic on both instances.
        do_reset();
        rnd_en = 1'b1;
        for (int i = 0; i < 2; i++) ack_dly[i] = int'($urandom_range(1, 4));
        repeat (3000) cycle();
        rnd_en = 1'b0;
        valid_a[0] = '0;
        valid_a[1] = '0;
        wait_idle(0);
        wait_idle(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
